mold_feed_arb: RTL and testbench

MOLD_FEED_ARB -- requirements
Module: mold_feed_arb

---
 rtl/mold_pkg.sv | 7 +
 rtl/mold_feed_arb.sv | 105 ++++++++++
 tb/tb_mold_feed_arb.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mold_pkg.sv
// mold_pkg: shared state encoding and default widths for the mold feed arbiter
package mold_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ABORT, DRAIN} state_t;
  localparam int AXI_DATA_W_DEF = 64;
  localparam int AXI_KEEP_W_DEF = AXI_DATA_W_DEF / 8;
  localparam int TO_CYC_DEF     = 200;
endpackage

// File: rtl/mold_feed_arb.sv
// mold_feed_arb: packet-granular round-robin arbiter of two UDP feeds into the moldudp64 parser
module mold_feed_arb
  import mold_pkg::*;
#(
  parameter int AXI_DATA_W = AXI_DATA_W_DEF,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int TO_W       = 8,
  parameter int TO_CYC     = TO_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  s0_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] s0_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] s0_axis_tdata_i,
  input  logic                  s0_axis_tlast_i,
  input  logic                  s0_axis_tuser_i,
  output logic                  s0_axis_tready_o,
  input  logic                  s1_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] s1_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] s1_axis_tdata_i,
  input  logic                  s1_axis_tlast_i,
  input  logic                  s1_axis_tuser_i,
  output logic                  s1_axis_tready_o,
  output logic                  m_axis_tvalid_o,
  output logic [AXI_KEEP_W-1:0] m_axis_tkeep_o,
  output logic [AXI_DATA_W-1:0] m_axis_tdata_o,
  output logic                  m_axis_tlast_o,
  output logic                  m_axis_tuser_o,
  input  logic                  m_axis_tready_i,
  output logic [1:0]            grant_o,
  output logic                  abort_v_o
);
  state_t state, state_nx;
  logic ptr, ptr_nx, gsel, gsel_nx, gv, gl;
  logic [TO_W-1:0] cnt, cnt_nx;
  assign gv = gsel ? s1_axis_tvalid_i : s0_axis_tvalid_i;
  assign gl = gsel ? s1_axis_tlast_i : s0_axis_tlast_i;
  assign grant_o = (state == IDLE) ? 2'b00 : {gsel, !gsel};
  always_ff @(posedge clk) begin
    if (nreset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      gsel  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      gsel  <= gsel_nx;
      cnt   <= cnt_nx;
    end
  end
  always_comb begin
    state_nx         = state;
    ptr_nx           = ptr;
    gsel_nx          = gsel;
    cnt_nx           = cnt;
    m_axis_tvalid_o  = 1'b0;
    m_axis_tkeep_o   = '0;
    m_axis_tdata_o   = '0;
    m_axis_tlast_o   = 1'b0;
    m_axis_tuser_o   = 1'b0;
    s0_axis_tready_o = 1'b0;
    s1_axis_tready_o = 1'b0;
    abort_v_o        = 1'b0;
    case (state)
      IDLE: if (s0_axis_tvalid_i | s1_axis_tvalid_i) begin
        gsel_nx  = (s0_axis_tvalid_i & s1_axis_tvalid_i) ? ptr : s1_axis_tvalid_i;
        cnt_nx   = '0;
        state_nx = BUSY;
      end
      BUSY: begin
        m_axis_tvalid_o  = gv;
        m_axis_tkeep_o   = gsel ? s1_axis_tkeep_i : s0_axis_tkeep_i;
        m_axis_tdata_o   = gsel ? s1_axis_tdata_i : s0_axis_tdata_i;
        m_axis_tlast_o   = gl;
        m_axis_tuser_o   = gsel ? s1_axis_tuser_i : s0_axis_tuser_i;
        s0_axis_tready_o = !gsel & m_axis_tready_i;
        s1_axis_tready_o = gsel & m_axis_tready_i;
        cnt_nx = gv ? '0 : (cnt == '1) ? cnt : cnt + TO_W'(1);
        // abort once this idle cycle brings the stall count up to TO_CYC
        if (gv & m_axis_tready_i & gl) begin
          state_nx = IDLE;
          ptr_nx   = !gsel;
        end else if (!gv && cnt >= TO_W'(TO_CYC - 1))
          state_nx = ABORT;
      end
      ABORT: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tlast_o  = 1'b1;
        m_axis_tuser_o  = 1'b1;
        abort_v_o       = m_axis_tready_i;
        state_nx        = m_axis_tready_i ? DRAIN : ABORT;
      end
      DRAIN: begin
        s0_axis_tready_o = !gsel;
        s1_axis_tready_o = gsel;
        if (gv & gl) begin
          state_nx = IDLE;
          ptr_nx   = !gsel;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mold_feed_arb.sv
// tb_mold_feed_arb: directed checks of arbitration, backpressure, stall abort and reset
module tb_mold_feed_arb;
  localparam logic [63:0] A0 = 64'hA000, A1 = 64'hA001, A2 = 64'hA002;
  localparam logic [63:0] B0 = 64'hB000, B1 = 64'hB001;
  logic clk, nreset, mr;
  logic s0v, s0l, s0u, s0r, s1v, s1l, s1u, s1r;
  logic [7:0] s0k, s1k, mk;
  logic [63:0] s0d, s1d, md;
  logic mv, ml, mu, abort_v;
  logic [1:0] grant;
  int checks = 0, errors = 0;
  mold_feed_arb dut (
    .clk(clk), .nreset(nreset),
    .s0_axis_tvalid_i(s0v), .s0_axis_tkeep_i(s0k), .s0_axis_tdata_i(s0d),
    .s0_axis_tlast_i(s0l), .s0_axis_tuser_i(s0u), .s0_axis_tready_o(s0r),
    .s1_axis_tvalid_i(s1v), .s1_axis_tkeep_i(s1k), .s1_axis_tdata_i(s1d),
    .s1_axis_tlast_i(s1l), .s1_axis_tuser_i(s1u), .s1_axis_tready_o(s1r),
    .m_axis_tvalid_o(mv), .m_axis_tkeep_o(mk), .m_axis_tdata_o(md),
    .m_axis_tlast_o(ml), .m_axis_tuser_o(mu), .m_axis_tready_i(mr),
    .grant_o(grant), .abort_v_o(abort_v)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    nreset = 1'b1;
    tick;
    tick;
    nreset = 1'b0;
  endtask
  initial begin
    int beat;
    logic bad, g;
    nreset = 1'b1; mr = 1'b1;
    s0v = 0; s0k = 8'hFF; s0d = '0; s0l = 0; s0u = 0;
    s1v = 0; s1k = 8'hFF; s1d = '0; s1l = 0; s1u = 0;
    tick;
    tick;
    chk("rst_grant", grant, 0);
    chk("rst_mvalid", mv, 0);
    chk("rst_s0rdy", s0r, 0);
    chk("rst_s1rdy", s1r, 0);
    chk("rst_abort", abort_v, 0);
    nreset = 1'b0;
    // feed A alone, three beats
    s0v = 1; s0d = A0;
    #1;
    chk("a3_idle_grant", grant, 0);
    chk("a3_idle_rdy", s0r, 0);
    tick;
    chk("a3_grant", grant, 2'b01);
    chk("a3_b0", md, A0);
    chk("a3_mvalid", mv, 1);
    chk("a3_s0rdy", s0r, 1);
    chk("a3_s1rdy", s1r, 0);
    tick;
    s0d = A1;
    #1;
    chk("a3_b1", md, A1);
    tick;
    s0d = A2; s0l = 1; s0u = 1; s0k = 8'h0F;
    #1;
    chk("a3_b2", md, A2);
    chk("a3_last", ml, 1);
    chk("a3_user", mu, 1);
    chk("a3_keep", mk, 8'h0F);
    tick;
    s0v = 0; s0l = 0; s0u = 0; s0k = 8'hFF;
    #1;
    chk("a3_end_grant", grant, 0);
    chk("a3_end_mvalid", mv, 0);
    // both feeds contend from reset exit; pointer must alternate
    s0v = 1; s0d = A0; s1v = 1; s1d = B0;
    do_reset;
    for (int p = 0; p < 4; p++) begin
      g = p[0];
      chk("rr_idle", grant, 0);
      tick;
      chk("rr_grant", grant, g ? 2'b10 : 2'b01);
      chk("rr_b0", md, g ? B0 : A0);
      chk("rr_other_rdy", g ? s0r : s1r, 0);
      if (g) begin s1d = B1; s1l = 1; end else begin s0d = A1; s0l = 1; end
      #1;
      chk("rr_b1", md, g ? B1 : A1);
      chk("rr_last", ml, 1);
      tick;
      s0d = A0; s0l = 0; s1d = B0; s1l = 0;
      #1;
    end
    // ready toggling on a four-beat A packet
    s0v = 1; s1v = 1; s0d = A0; s0l = 0;
    do_reset;
    tick;
    beat = 0;
    for (int i = 0; i < 20 && beat < 4; i++) begin
      mr = !i[0];
      s0d = A0 + 64'(beat); s0l = (beat == 3);
      #1;
      chk("bp_data", md, A0 + 64'(beat));
      chk("bp_s0rdy", s0r, mr);
      chk("bp_s1rdy", s1r, 0);
      tick;
      if (mr) beat++;
    end
    chk("bp_beats", 64'(beat), 4);
    s0v = 0; s1v = 0; s0l = 0; mr = 1;
    #1;
    chk("bp_end_grant", grant, 0);
    // stall of 200 cycles forces an abort beat then drain
    s0v = 1; s0d = A0; s1v = 1; s1d = B0; s1l = 1;
    do_reset;
    tick;
    chk("to_grant", grant, 2'b01);
    tick;
    s0v = 0; mr = 0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (mv !== 0 || grant !== 2'b01 || s1r !== 0) bad = 1;
      tick;
    end
    chk("to_stall_quiet", bad, 0);
    chk("to_ab_valid", mv, 1);
    chk("to_ab_keep", mk, 0);
    chk("to_ab_data", md, 0);
    chk("to_ab_last", ml, 1);
    chk("to_ab_user", mu, 1);
    chk("to_ab_rdy", {s0r, s1r}, 0);
    chk("to_ab_nopulse", abort_v, 0);
    tick;
    chk("to_ab_hold", mv, 1);
    mr = 1;
    #1;
    chk("to_ab_pulse", abort_v, 1);
    tick;
    chk("to_pulse_once", abort_v, 0);
    s0v = 1; s0d = A1;
    #1;
    chk("to_dr_mvalid", mv, 0);
    chk("to_dr_s0rdy", s0r, 1);
    chk("to_dr_s1rdy", s1r, 0);
    chk("to_dr_grant", grant, 2'b01);
    tick;
    s0d = A2; s0l = 1;
    #1;
    chk("to_dr_s0rdy2", s0r, 1);
    tick;
    s0v = 0; s0l = 0;
    #1;
    chk("to_idle", grant, 0);
    tick;
    chk("to_b_grant", grant, 2'b10);
    chk("to_b_data", md, B0);
    chk("to_b_last", ml, 1);
    tick;
    s1v = 0; s1l = 0;
    // stall of 199 cycles must not abort
    s0v = 1; s0d = A0;
    do_reset;
    tick;
    tick;
    s0v = 0;
    bad = 0;
    for (int i = 0; i < 199; i++) begin
      #1;
      if (mv !== 0 || grant !== 2'b01 || abort_v !== 0) bad = 1;
      tick;
    end
    chk("st199_quiet", bad, 0);
    s0v = 1; s0d = A1; s0l = 1;
    #1;
    chk("st199_valid", mv, 1);
    chk("st199_data", md, A1);
    chk("st199_keep", mk, 8'hFF);
    chk("st199_last", ml, 1);
    tick;
    s0v = 0; s0l = 0;
    #1;
    chk("st199_idle", grant, 0);
    chk("st199_mvalid", mv, 0);
    // reset mid-packet, then a fresh packet
    s0v = 1; s0d = A0;
    do_reset;
    tick;
    tick;
    s0d = A1;
    nreset = 1;
    tick;
    chk("mr_mvalid", mv, 0);
    chk("mr_grant", grant, 0);
    chk("mr_s0rdy", s0r, 0);
    nreset = 0;
    s0d = 64'h55; s0l = 1;
    tick;
    chk("mr_new_grant", grant, 2'b01);
    chk("mr_new_data", md, 64'h55);
    chk("mr_new_last", ml, 1);
    tick;
    s0v = 0; s0l = 0;
    #1;
    chk("mr_new_idle", grant, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
